lcd_power_sequencer: RTL and testbench

Power-on/power-off sequencer for the LCD multimedia HSMC panel. It drives the panel supply enable, the NCLK gate, the panel global reset and the backlight enable in a fixed, timed order. Once the panel is ready, it hands the global reset over to the host. It sits between the host control logic and the pin-level LCD power, clock and reset muxing in the MAX II.

---
 rtl/lcd_power_sequencer.sv | 160 ++++++++++++++++
 tb/tb_lcd_power_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_power_sequencer.sv
// LCD panel power sequencer: supply, NCLK gate, global reset and backlight
// are switched in a fixed, timed order; the host owns the panel reset in READY.
// Optional power-good fault handling is enabled by defining LCD_SEQ_FAULT_EN.
module lcd_power_sequencer #(
  parameter int unsigned      CNT_W = 20,
  parameter logic [CNT_W-1:0] T_PWR = 20'd100000,
  parameter logic [CNT_W-1:0] T_CLK = 20'd1000,
  parameter logic [CNT_W-1:0] T_RST = 20'd500,
  parameter logic [CNT_W-1:0] T_BL  = 20'd200
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iENABLE,
  input  logic       iHC_GREST_n,
`ifdef LCD_SEQ_FAULT_EN
  input  logic       iPG,
`endif
  output logic       oPWR_EN,
  output logic       oNCLK_EN,
  output logic       oGREST_n,
  output logic       oBL_EN,
  output logic       oREADY,
  output logic       oFAULT,
  output logic [3:0] oSTATE
);

  typedef enum logic [3:0] {
    S_OFF        = 4'd0,
    S_PWR_UP     = 4'd1,
    S_CLK_ON     = 4'd2,
    S_RST_REL    = 4'd3,
    S_READY      = 4'd4,
    S_BL_OFF     = 4'd5,
    S_RST_ASSERT = 4'd6,
    S_CLK_OFF    = 4'd7,
    S_PWR_DN     = 4'd8,
    S_FAULT      = 4'd9
  } state_t;

  // Last counter value of each dwell; a zero dwell behaves like one cycle.
  localparam logic [CNT_W-1:0] L_PWR = (T_PWR == '0) ? '0 : T_PWR - 1'b1;
  localparam logic [CNT_W-1:0] L_CLK = (T_CLK == '0) ? '0 : T_CLK - 1'b1;
  localparam logic [CNT_W-1:0] L_RST = (T_RST == '0) ? '0 : T_RST - 1'b1;
  localparam logic [CNT_W-1:0] L_BL  = (T_BL  == '0) ? '0 : T_BL  - 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last;
  logic             timed, expired, pg_ok;

`ifdef LCD_SEQ_FAULT_EN
  assign pg_ok = iPG;
`else
  assign pg_ok = 1'b1;
`endif

  // Dwell length of the current state; untimed states never expire.
  always_comb begin
    last  = '0;
    timed = 1'b1;
    case (state_q)
      S_PWR_UP, S_PWR_DN:     last = L_PWR;
      S_CLK_ON, S_CLK_OFF:    last = L_CLK;
      S_RST_REL, S_RST_ASSERT: last = L_RST;
      S_BL_OFF:               last = L_BL;
      default:                timed = 1'b0;
    endcase
  end

  assign expired = timed && (cnt_q == last);

  // Next-state: power-good fault beats abort, abort beats dwell expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:        if (iENABLE) state_d = S_PWR_UP;
      S_PWR_UP: begin
        if (expired && !pg_ok) state_d = S_FAULT;
        else if (!iENABLE)     state_d = S_PWR_DN;
        else if (expired)      state_d = S_CLK_ON;
      end
      S_CLK_ON: begin
        if (!pg_ok)         state_d = S_FAULT;
        else if (!iENABLE)  state_d = S_CLK_OFF;
        else if (expired)   state_d = S_RST_REL;
      end
      S_RST_REL: begin
        if (!pg_ok)         state_d = S_FAULT;
        else if (!iENABLE)  state_d = S_RST_ASSERT;
        else if (expired)   state_d = S_READY;
      end
      S_READY: begin
        if (!pg_ok)         state_d = S_FAULT;
        else if (!iENABLE)  state_d = S_BL_OFF;
      end
      S_BL_OFF: begin
        if (!pg_ok)         state_d = S_FAULT;
        else if (expired)   state_d = S_RST_ASSERT;
      end
      S_RST_ASSERT: begin
        if (!pg_ok)         state_d = S_FAULT;
        else if (expired)   state_d = S_CLK_OFF;
      end
      S_CLK_OFF:    if (expired) state_d = S_PWR_DN;
      S_PWR_DN:     if (expired) state_d = S_OFF;
      S_FAULT:      if (!iENABLE) state_d = S_OFF;
      default:      state_d = S_OFF;
    endcase
  end

  // Dwell counter: clears on any state change, saturates at the last value.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)       cnt_d = '0;
    else if (timed && !expired)   cnt_d = cnt_q + 1'b1;
  end

  // State and counter registers.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode; only the READY reset follows the host directly.
  always_comb begin
    oPWR_EN  = 1'b0;
    oNCLK_EN = 1'b0;
    oGREST_n = 1'b0;
    oBL_EN   = 1'b0;
    oREADY   = 1'b0;
    oFAULT   = 1'b0;
    case (state_q)
      S_PWR_UP:     oPWR_EN = 1'b1;
      S_CLK_ON:     begin oPWR_EN = 1'b1; oNCLK_EN = 1'b1; end
      S_RST_REL:    begin oPWR_EN = 1'b1; oNCLK_EN = 1'b1; oGREST_n = 1'b1; end
      S_READY: begin
        oPWR_EN  = 1'b1;
        oNCLK_EN = 1'b1;
        oGREST_n = iHC_GREST_n;
        oBL_EN   = 1'b1;
        oREADY   = 1'b1;
      end
      S_BL_OFF:     begin oPWR_EN = 1'b1; oNCLK_EN = 1'b1; oGREST_n = 1'b1; end
      S_RST_ASSERT: begin oPWR_EN = 1'b1; oNCLK_EN = 1'b1; end
      S_CLK_OFF:    oPWR_EN = 1'b1;
`ifdef LCD_SEQ_FAULT_EN
      S_FAULT:      oFAULT = 1'b1;
`endif
      default: ;
    endcase
  end

  assign oSTATE = state_q;

endmodule

// File: tb/tb_lcd_power_sequencer.sv
// Directed bench for lcd_power_sequencer with short dwells
// (T_PWR=8, T_CLK=4, T_RST=3, T_BL=2) plus a T_BL=0 instance.
module tb_lcd_power_sequencer;
  logic iCLK = 1'b0;
  logic iRST_n = 1'b1;
  logic en = 1'b0, en_z = 1'b0, hc = 1'b1, pg = 1'b1;
  logic pwr, nclk, grst, bl, rdy, flt;
  logic [3:0] st;
  logic pwr_z, nclk_z, grst_z, bl_z, rdy_z, flt_z;
  logic [3:0] st_z;
  int total = 0, bad = 0;

  always #5 iCLK = ~iCLK;

  lcd_power_sequencer #(.CNT_W(20), .T_PWR(20'd8), .T_CLK(20'd4), .T_RST(20'd3), .T_BL(20'd2)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iENABLE(en), .iHC_GREST_n(hc),
`ifdef LCD_SEQ_FAULT_EN
    .iPG(pg),
`endif
    .oPWR_EN(pwr), .oNCLK_EN(nclk), .oGREST_n(grst), .oBL_EN(bl),
    .oREADY(rdy), .oFAULT(flt), .oSTATE(st));

  lcd_power_sequencer #(.CNT_W(20), .T_PWR(20'd8), .T_CLK(20'd4), .T_RST(20'd3), .T_BL(20'd0)) dut_z (
    .iCLK(iCLK), .iRST_n(iRST_n), .iENABLE(en_z), .iHC_GREST_n(hc),
`ifdef LCD_SEQ_FAULT_EN
    .iPG(pg),
`endif
    .oPWR_EN(pwr_z), .oNCLK_EN(nclk_z), .oGREST_n(grst_z), .oBL_EN(bl_z),
    .oREADY(rdy_z), .oFAULT(flt_z), .oSTATE(st_z));

  // Expected {state, PWR, CLK, GREST_n, BL, READY, FAULT} from the state table.
  function automatic logic [9:0] exp_vec(input logic [3:0] s, input logic h);
    case (s)
      4'd0: exp_vec = {s, 6'b000000};
      4'd1: exp_vec = {s, 6'b100000};
      4'd2: exp_vec = {s, 6'b110000};
      4'd3: exp_vec = {s, 6'b111000};
      4'd4: exp_vec = {s, 2'b11, h, 3'b110};
      4'd5: exp_vec = {s, 6'b111000};
      4'd6: exp_vec = {s, 6'b110000};
      4'd7: exp_vec = {s, 6'b100000};
      4'd8: exp_vec = {s, 6'b000000};
      4'd9: exp_vec = {s, 6'b000001};
      default: exp_vec = 10'h3ff;
    endcase
  endfunction

  wire [9:0] obs   = {st, pwr, nclk, grst, bl, rdy, flt};
  wire [9:0] obs_z = {st_z, pwr_z, nclk_z, grst_z, bl_z, rdy_z, flt_z};

  task automatic test_reset;
    #2 iRST_n = 1'b0;
    #1 total++;
    if (obs !== exp_vec(4'd0, 1'b1)) begin
      bad++; $display("FAIL reset_state: got %b want %b", obs, exp_vec(4'd0, 1'b1));
    end
    @(posedge iCLK); #1 iRST_n = 1'b1;
    @(posedge iCLK); #1 total++;
    if (obs !== exp_vec(4'd0, 1'b1)) begin
      bad++; $display("FAIL reset_hold_off: got %b want %b", obs, exp_vec(4'd0, 1'b1));
    end
  endtask

  // Up sequence from OFF; ends in READY after edge 15.
  task automatic test_power_up;
    logic [3:0] s;
    en = 1'b1;
    for (int e = 0; e <= 15; e++) begin
      @(posedge iCLK); #1;
      s = (e < 8) ? 4'd1 : (e < 12) ? 4'd2 : (e < 15) ? 4'd3 : 4'd4;
      total++;
      if (obs !== exp_vec(s, hc)) begin
        bad++; $display("FAIL power_up e=%0d: got %b want %b", e, obs, exp_vec(s, hc));
      end
    end
    hc = 1'b0; #1 total++;
    if (grst !== 1'b0) begin bad++; $display("FAIL host_grest_lo: got %b want 0", grst); end
    hc = 1'b1; #1 total++;
    if (grst !== 1'b1) begin bad++; $display("FAIL host_grest_hi: got %b want 1", grst); end
  endtask

  // Called from READY: full graceful power-down.
  task automatic test_power_down;
    logic [3:0] s;
    en = 1'b0;
    for (int k = 0; k <= 18; k++) begin
      @(posedge iCLK); #1;
      s = (k < 2) ? 4'd5 : (k < 5) ? 4'd6 : (k < 9) ? 4'd7 : (k < 17) ? 4'd8 : 4'd0;
      total++;
      if (obs !== exp_vec(s, hc)) begin
        bad++; $display("FAIL power_down k=%0d: got %b want %b", k, obs, exp_vec(s, hc));
      end
    end
  endtask

  // Abort in CLK_ON, then re-raise enable during PWR_DN.
  task automatic test_abort;
    logic [3:0] s;
    @(posedge iCLK); #1 iRST_n = 1'b0; en = 1'b0; #2 iRST_n = 1'b1;
    en = 1'b1;
    for (int e = 0; e <= 22; e++) begin
      if (e == 9) en = 1'b0;
      if (e == 15) en = 1'b1;
      @(posedge iCLK); #1;
      s = (e < 8) ? 4'd1 : (e == 8) ? 4'd2 : (e < 13) ? 4'd7 :
          (e < 21) ? 4'd8 : (e == 21) ? 4'd0 : 4'd1;
      total++;
      if (obs !== exp_vec(s, hc)) begin
        bad++; $display("FAIL abort e=%0d: got %b want %b", e, obs, exp_vec(s, hc));
      end
    end
  endtask

  // Async reset inside RST_REL, then a clean restart.
  task automatic test_reset_mid;
    @(posedge iCLK); #1 iRST_n = 1'b0; en = 1'b0; #2 iRST_n = 1'b1;
    en = 1'b1;
    for (int e = 0; e <= 13; e++) @(posedge iCLK);
    #1 total++;
    if (obs !== exp_vec(4'd3, hc)) begin
      bad++; $display("FAIL mid_pre: got %b want %b", obs, exp_vec(4'd3, hc));
    end
    iRST_n = 1'b0; #1 total++;
    if (obs !== exp_vec(4'd0, hc)) begin
      bad++; $display("FAIL mid_async: got %b want %b", obs, exp_vec(4'd0, hc));
    end
    #2 iRST_n = 1'b1;
    @(posedge iCLK); #1 total++;
    if (obs !== exp_vec(4'd1, hc)) begin
      bad++; $display("FAIL mid_restart: got %b want %b", obs, exp_vec(4'd1, hc));
    end
  endtask

  // T_BL=0 instance: BL_OFF lasts exactly one cycle.
  task automatic test_zero_dwell;
    @(posedge iCLK); #1 iRST_n = 1'b0; en = 1'b0; #2 iRST_n = 1'b1;
    en_z = 1'b1;
    for (int e = 0; e <= 15; e++) @(posedge iCLK);
    #1 total++;
    if (obs_z !== exp_vec(4'd4, hc)) begin
      bad++; $display("FAIL zero_ready: got %b want %b", obs_z, exp_vec(4'd4, hc));
    end
    en_z = 1'b0;
    @(posedge iCLK); #1 total++;
    if (obs_z !== exp_vec(4'd5, hc)) begin
      bad++; $display("FAIL zero_bl_off: got %b want %b", obs_z, exp_vec(4'd5, hc));
    end
    @(posedge iCLK); #1 total++;
    if (obs_z !== exp_vec(4'd6, hc)) begin
      bad++; $display("FAIL zero_rst_assert: got %b want %b", obs_z, exp_vec(4'd6, hc));
    end
  endtask

`ifdef LCD_SEQ_FAULT_EN
  task automatic test_fault;
    logic [3:0] s;
    @(posedge iCLK); #1 iRST_n = 1'b0; en = 1'b0; #2 iRST_n = 1'b1;
    pg = 1'b0; en = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      @(posedge iCLK); #1;
      s = (e < 8) ? 4'd1 : 4'd9;
      total++;
      if (obs !== exp_vec(s, hc)) begin
        bad++; $display("FAIL fault_pg e=%0d: got %b want %b", e, obs, exp_vec(s, hc));
      end
    end
    en = 1'b0;
    @(posedge iCLK); #1 total++;
    if (obs !== exp_vec(4'd0, hc)) begin
      bad++; $display("FAIL fault_exit: got %b want %b", obs, exp_vec(4'd0, hc));
    end
    pg = 1'b1; en = 1'b1;
    for (int e = 0; e <= 15; e++) @(posedge iCLK);
    #1 total++;
    if (obs !== exp_vec(4'd4, hc)) begin
      bad++; $display("FAIL fault_ready: got %b want %b", obs, exp_vec(4'd4, hc));
    end
    pg = 1'b0;
    @(posedge iCLK); #1 total++;
    if (obs !== exp_vec(4'd9, hc)) begin
      bad++; $display("FAIL fault_ready_pg: got %b want %b", obs, exp_vec(4'd9, hc));
    end
    pg = 1'b1; en = 1'b0;
    @(posedge iCLK); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    @(posedge iCLK); #1;
    test_power_down();
    test_abort();
    test_reset_mid();
    test_zero_dwell();
`ifdef LCD_SEQ_FAULT_EN
    test_fault();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
